// File: rtl/tl_tx_fc_gate.sv
// tl_tx_fc_gate: transmit flow-control credit gate.
// Holds the partner's advertised credit limits (CL) and the credits consumed
// (CC) per tl_credit_t field, and admits a TLP only when its header and data
// needs fit under the modular credit rule.
// Optional stall monitor: define TL_FC_STALL_MON_EN.
// Field index map: 0 ph, 1 pd, 2 nph, 3 npd, 4 cplh, 5 cpld
// (header = 2*type, data = 2*type+1).
module tl_tx_fc_gate #(
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fc_init_valid,
  input  logic        fc_update_valid,
  input  logic [63:0] fc_limit,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic        req_has_data,
  input  logic [9:0]  req_len,
  output logic        fc_inited,
  output logic [63:0] fc_avail,
  output logic        fc_stall_err
);

  if ((STALL_LIMIT >> STALL_CNT_W) != 0) begin : g_bad_cfg
    $error("STALL_CNT_W too narrow for STALL_LIMIT");
  end

  typedef enum logic {WAIT_INIT, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [11:0] cl [6];
  logic [11:0] cc [6];
  logic [5:0]  inf;
  logic [11:0] av [6];
  logic [2:0]  hdr_f, dat_f;
  logic [11:0] need_dat;
  logic [10:0] len_p3;
  logic        accept;

  function automatic logic narrow(input int unsigned f);
    return (f == 2) || (f == 4);
  endfunction

  function automatic logic [11:0] wmask(input int unsigned f);
    return narrow(f) ? 12'h0FF : 12'hFFF;
  endfunction

  function automatic logic [11:0] fld(input logic [63:0] v, input int unsigned f);
    case (f)
      0:       return v[63:52];
      1:       return v[51:40];
      2:       return {4'h0, v[39:32]};
      3:       return v[31:20];
      4:       return {4'h0, v[19:12]};
      default: return v[11:0];
    endcase
  endfunction

  function automatic logic suff(input logic [11:0] lim, input logic [11:0] used,
                                input logic [11:0] need, input logic is_inf,
                                input int unsigned f);
    logic [11:0] d;
    d = (lim - used - need) & wmask(f);
    return is_inf || (need == 12'd0) || (d <= (narrow(f) ? 12'd128 : 12'd2048));
  endfunction

  // Field selection and data-credit need (len 0 means 1024 DW)
  always_comb begin
    hdr_f    = (req_type == 2'd3) ? 3'd0 : {req_type, 1'b0};
    dat_f    = (req_type == 2'd3) ? 3'd1 : {req_type, 1'b1};
    len_p3   = {1'b0, req_len} + 11'd3;
    need_dat = '0;
    if (req_has_data)
      need_dat = (req_len == 10'd0) ? 12'd256 : {3'b000, len_p3[10:2]};
  end

  // Ready: ACTIVE, no re-init this cycle, legal type, both fields sufficient
  always_comb begin
    req_ready = (state == ACTIVE) && !fc_init_valid && (req_type != 2'd3) &&
                suff(cl[hdr_f], cc[hdr_f], 12'd1, inf[hdr_f], 32'(hdr_f)) &&
                suff(cl[dat_f], cc[dat_f], need_dat, inf[dat_f], 32'(dat_f));
  end

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_INIT;
    else     state <= state_nxt;
  end

  // Next state: any init pulse lands in (or stays in) ACTIVE
  always_comb begin
    state_nxt = state;
    if (fc_init_valid) state_nxt = ACTIVE;
  end

  // Credit limits, consumed counters and infinite flags
  always_ff @(posedge clk) begin
    if (rst) begin
      inf <= '0;
      for (int unsigned f = 0; f < 6; f++) begin
        cl[f] <= '0;
        cc[f] <= '0;
      end
    end else if (fc_init_valid) begin
      for (int unsigned f = 0; f < 6; f++) begin
        inf[f] <= (fld(fc_limit, f) == 12'd0);
        cl[f]  <= fld(fc_limit, f);
        cc[f]  <= '0;
      end
    end else begin
      if (fc_update_valid && state == ACTIVE) begin
        for (int unsigned f = 0; f < 6; f++)
          if (!inf[f]) cl[f] <= fld(fc_limit, f);
      end
      if (accept) begin
        cc[hdr_f] <= (cc[hdr_f] + 12'd1) & wmask(32'(hdr_f));
        cc[dat_f] <= (cc[dat_f] + need_dat) & wmask(32'(dat_f));
      end
    end
  end

  // Available credits per field
  always_comb begin
    for (int unsigned f = 0; f < 6; f++) begin
      av[f] = '0;
      if (state == ACTIVE)
        av[f] = inf[f] ? wmask(f) : ((cl[f] - cc[f]) & wmask(f));
    end
  end

  assign fc_avail  = {av[0], av[1], av[2][7:0], av[3], av[4][7:0], av[5]};
  assign fc_inited = (state == ACTIVE);

`ifdef TL_FC_STALL_MON_EN
  localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);

  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   stall_err;

  // Stall counter: counts blocked cycles, saturates at LIMIT; error is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else if (state != ACTIVE || fc_init_valid || !req_valid || req_ready) begin
      stall_cnt <= '0;
    end else if (stall_cnt != LIMIT) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == LIMIT - 1'b1) stall_err <= 1'b1;
    end
  end

  assign fc_stall_err = stall_err;
`else
  assign fc_stall_err = 1'b0;
`endif

endmodule
